mem_loader: RTL
===============

# mem_loader

Byte-stream program loader that writes 6502 opcodes and data into the `memory_block` address space through its native single-port interface (enable, write enable, 16-bit address, 8-bit data). It is the write-side counterpart to the sequential read sweep used to inspect memory. It sits between a byte source (UART receiver or bench driver) and the memory port. `busy` holds the CPU in reset while a load is in progress.

## Interface

Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_CYCLES`, 16'd50000, maximum idle cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- `clk_sys`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  incoming stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte. A byte transfers on an edge where `rx_valid && rx_ready`.
- `mem_en`  out  1  memory enable; drives `ena`.
- `mem_we`  out  1  memory write enable; drives `wea`.
- `mem_addr`  out  16  memory address; drives `addra`.
- `mem_wdata`  out  8  write data; drives `dina`.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame ends, on either success or error.
- `err`  out  1  valid with `done`: 1 means the frame failed.
- `err_code`  out  2  valid with `done`: 00 ok, 01 checksum mismatch, 10 timeout.

## Operation

Frame format, in order: `SYNC_BYTE`, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes, CHK.
- CHK equals the 8-bit sum (mod 256) of the data bytes.

States: IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, WRITE, CHK, FINISH.
- **IDLE:** accepts bytes continuously. Bytes other than `SYNC_BYTE` are discarded. `SYNC_BYTE` → ADDR_LO; clears the checksum accumulator.
- **ADDR_LO → ADDR_HI → LEN_LO → LEN_HI:** each state latches one byte into the address or length register.
- **LEN_HI:** if the assembled length is 0, go to CHK; otherwise go to DATA.
- **DATA:** an accepted byte is registered into `mem_wdata`, the accumulator adds the byte, and the state moves to WRITE.
- **WRITE:** one cycle with `mem_en=1`, `mem_we=1`, `rx_ready=0`. Then the address increments and the remaining count decrements. Next state is DATA if the remaining count is nonzero, otherwise CHK.
- **Address arithmetic:** 16-bit, wraps 16'hFFFF → 16'h0000 with no error.
- **CHK:** the accepted byte is compared with the accumulator, then → FINISH.
- **FINISH:** one cycle with `done=1`. `err`/`err_code` reflect the compare result. Then → IDLE.
  - Data already written is not rolled back on a checksum error.
- **Timeout:** a counter clears on every accepted byte and in IDLE. It increments each cycle while in ADDR_LO..CHK (excluding WRITE) with no transfer. When the count reaches `TIMEOUT_CYCLES` (nonzero), go to FINISH with `err=1`, `err_code=10`.
- `rx_ready = 1` in every state except WRITE and FINISH.
- `busy = 1` in every state except IDLE.
- `mem_en` and `mem_we` are 0 outside WRITE.
- `mem_addr` holds its last value; `mem_wdata` holds the last written byte.

## Timing

- **Reset values:** state IDLE, `rx_ready=1`, `mem_en=0`, `mem_we=0`, `mem_addr=16'h0000`, `mem_wdata=8'h00`, `busy=0`, `done=0`, `err=0`, `err_code=00`, accumulator 0, timeout counter 0.
- Asserting `reset_n` mid-frame aborts the frame immediately. No `done` pulse is issued, and a write in flight is dropped (`mem_we` goes 0 asynchronously).
- **Write latency:** a data byte accepted at edge k gives `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` valid between edges k and k+1. The memory captures the write at edge k+1.
- **Throughput:** one data byte per 2 cycles; header bytes at 1 per cycle.
- `done` is asserted in the cycle after the CHK byte is accepted, or in the cycle after the timeout count is reached.
- `busy` rises the cycle after the SYNC byte is accepted and falls the cycle after `done`.
- A byte presented during FINISH is not accepted; it remains pending and is evaluated in IDLE on the next cycle.
- All outputs are registered, except `rx_ready`, which is decoded from the state register.

## Test plan

- **Basic load:** frame A5 00 02 03 00 A9 01 EA, CHK 94. Expect three one-cycle writes: 0x0200=A9, 0x0201=01, 0x0202=EA. Then `done=1`, `err=0`. Read back via `douta` matches.
- **Checksum error:** same frame with CHK 00. Expect the three writes still performed, then `done=1`, `err=1`, `err_code=01`.
- **Wrap-around:** ADDR FFFE, LEN 3, data 11 22 33, CHK 66. Expect writes at FFFE, FFFF, 0000 in that order, then `done`, `err=0`.
- **Resync and zero length:** leading bytes 00 FF 5A, then A5 34 12 00 00, CHK 00. Expect the leading bytes discarded, no memory writes, `done=1`, `err=0`.
- **Timeout:** `TIMEOUT_CYCLES=20`; send A5 00 03 then stop. Expect `done=1`, `err_code=10` exactly 20 cycles after the last accepted byte (plus 1 for FINISH), then `busy=0`.
- **Reset mid-frame:** assert `reset_n=0` during a WRITE cycle. Expect `mem_we=0` immediately, all outputs at reset values, and no `done` pulse. A following full frame loads correctly.

Source files
------------

// File: rtl/mem_loader.sv
// Byte-stream program loader: parses SYNC/addr/len/data/chk frames and writes the
// data bytes through a single-port memory interface, one write per two cycles.
module mem_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    StIdle, StAddrLo, StAddrHi, StLenLo, StLenHi, StData, StWrite, StChk, StFinish
  } state_e;

  state_e      state_q;
  logic [15:0] addr_q;
  logic [15:0] rem_q;
  logic [15:0] tmo_q;
  logic [7:0]  acc_q;
  logic        xfer;
  logic        counting;
  logic        tmo_hit;
  logic        chk_bad;

  assign rx_ready = (state_q != StWrite) && (state_q != StFinish);
  assign xfer     = rx_valid && rx_ready;
  assign counting = (state_q != StIdle) && (state_q != StWrite) && (state_q != StFinish);
  assign tmo_hit  = (TIMEOUT_CYCLES != 16'd0) && counting && (tmo_q == TIMEOUT_CYCLES);
  assign chk_bad  = (rx_data != acc_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= 16'h0000;
      rem_q     <= 16'h0000;
      tmo_q     <= 16'h0000;
      acc_q     <= 8'h00;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      done   <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;

      if (!counting || xfer) begin
        tmo_q <= 16'h0000;
      end else begin
        tmo_q <= tmo_q + 16'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (xfer && rx_data == SYNC_BYTE) begin
            state_q <= StAddrLo;
            acc_q   <= 8'h00;
            busy    <= 1'b1;
          end
        end
        StAddrLo: if (xfer) begin
          addr_q[7:0] <= rx_data;
          state_q     <= StAddrHi;
        end
        StAddrHi: if (xfer) begin
          addr_q[15:8] <= rx_data;
          state_q      <= StLenLo;
        end
        StLenLo: if (xfer) begin
          rem_q[7:0] <= rx_data;
          state_q    <= StLenHi;
        end
        StLenHi: if (xfer) begin
          rem_q[15:8] <= rx_data;
          state_q     <= ({rx_data, rem_q[7:0]} == 16'd0) ? StChk : StData;
        end
        StData: if (xfer) begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= addr_q;
          mem_wdata <= rx_data;
          acc_q     <= acc_q + rx_data;
          state_q   <= StWrite;
        end
        StWrite: begin
          addr_q  <= addr_q + 16'd1;
          rem_q   <= rem_q - 16'd1;
          state_q <= (rem_q == 16'd1) ? StChk : StData;
        end
        StChk: if (xfer) begin
          done     <= 1'b1;
          err      <= chk_bad;
          err_code <= chk_bad ? 2'b01 : 2'b00;
          state_q  <= StFinish;
        end
        StFinish: begin
          busy     <= 1'b0;
          err      <= 1'b0;
          err_code <= 2'b00;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Idle gap inside a frame: abandon it with a timeout result.
      if (tmo_hit && !xfer) begin
        done     <= 1'b1;
        err      <= 1'b1;
        err_code <= 2'b10;
        state_q  <= StFinish;
      end
    end
  end

endmodule
